// File: rtl/noc_cv_bridge_pkg.sv
// Shared types and sizing helpers for the credit <-> val/rdy NoC bridge.
package noc_cv_bridge_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_CRED = 2'd2
  } err_code_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Register-array flit FIFO with wrap-around pointers, valid for any DEPTH >= 2.
// A push while full is dropped (o_overflow strobes) unless a pop frees a slot that cycle.
module noc_flit_fifo
  import noc_cv_bridge_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow
);

  localparam int               PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]    LAST     = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign o_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!w_full || w_do_pop);
  assign o_overflow = i_push && !w_do_push;
  assign o_data     = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // NOTE: storage needs no reset; an entry is only read after the count says it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/noc_credit_valrdy_bridge.sv
// Multi-channel bridge: credit-in -> val/rdy-out (A, buffered) and val/rdy-in -> credit-out (B).
// Channels are independent; per-channel idle and sticky error flags support quiesce.
module noc_credit_valrdy_bridge
  import noc_cv_bridge_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 64,
  parameter int CRED_DEPTH = 4,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        a_cr_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] a_cr_data_in,
  output logic [NUM_CH-1:0]        a_cr_yummy_out,
  output logic [NUM_CH-1:0]        a_vr_valid_out,
  output logic [NUM_CH*DATA_W-1:0] a_vr_data_out,
  input  logic [NUM_CH-1:0]        a_vr_ready_in,
  input  logic [NUM_CH-1:0]        b_vr_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] b_vr_data_in,
  output logic [NUM_CH-1:0]        b_vr_ready_out,
  output logic [NUM_CH-1:0]        b_cr_valid_out,
  output logic [NUM_CH*DATA_W-1:0] b_cr_data_out,
  input  logic [NUM_CH-1:0]        b_cr_yummy_in,
  output logic [NUM_CH-1:0]        idle,
  output logic [NUM_CH-1:0]        err_overflow,
  output logic [NUM_CH-1:0]        err_credit
);

  localparam int            CW       = cnt_w(max_i(BUF_DEPTH, CRED_DEPTH));
  localparam logic [CW-1:0] CRED_MAX = CW'(CRED_DEPTH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic              w_a_pop;
    logic              w_a_empty;
    logic              w_a_ovf;
    logic [CW-1:0]     w_a_count;
    logic [DATA_W-1:0] w_a_head;
    logic              w_b_ready;
    logic              w_b_acc;
    logic              r_a_yummy;
    logic              r_err_ovf;
    logic              r_b_valid;
    logic [DATA_W-1:0] r_b_data;
    logic [CW-1:0]     r_cred;
    logic              r_err_cred;

    assign w_a_pop = !w_a_empty && a_vr_ready_in[c];

    noc_flit_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (BUF_DEPTH),
      .CNT_W  (CW)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (a_cr_valid_in[c]),
      .i_data     (a_cr_data_in[c*DATA_W +: DATA_W]),
      .i_pop      (w_a_pop),
      .o_data     (w_a_head),
      .o_empty    (w_a_empty),
      .o_count    (w_a_count),
      .o_overflow (w_a_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a_yummy <= 1'b0;
        r_err_ovf <= 1'b0;
      end else begin
        r_a_yummy <= w_a_pop;
        if (w_a_ovf) r_err_ovf <= 1'b1;
      end
    end

    // A yummy arriving with an accept is a credit swap, so the count holds even at CRED_MAX.
    assign w_b_ready = (r_cred != '0);
    assign w_b_acc   = b_vr_valid_in[c] && w_b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cred     <= CRED_MAX;
        r_err_cred <= 1'b0;
        r_b_valid  <= 1'b0;
        r_b_data   <= '0;
      end else begin
        r_b_valid <= w_b_acc;
        if (w_b_acc) r_b_data <= b_vr_data_in[c*DATA_W +: DATA_W];
        if (w_b_acc && !b_cr_yummy_in[c]) begin
          r_cred <= r_cred - 1'b1;
        end else if (!w_b_acc && b_cr_yummy_in[c]) begin
          if (r_cred == CRED_MAX) r_err_cred <= 1'b1;
          else                    r_cred     <= r_cred + 1'b1;
        end
      end
    end

    assign a_cr_yummy_out[c]                = r_a_yummy;
    assign a_vr_valid_out[c]                = !w_a_empty;
    assign a_vr_data_out[c*DATA_W +: DATA_W] = w_a_head;
    assign b_vr_ready_out[c]                = w_b_ready;
    assign b_cr_valid_out[c]                = r_b_valid;
    assign b_cr_data_out[c*DATA_W +: DATA_W] = r_b_data;
    assign idle[c]                          = (w_a_count == '0) && (r_cred == CRED_MAX);
    assign err_overflow[c]                  = r_err_ovf;
    assign err_credit[c]                    = r_err_cred;
  end

endmodule
